// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types, default widths and saturation helper for the neuron MAC sequencer
package neuron_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [2:0] {
    IDLE,
    RD_X,
    RD_W,
    WRITE,
    DONE
  } state_t;

  // Clamp the accumulator to the largest value a RAM word can hold.
  function automatic logic [DATA_W_DEF-1:0] saturate(input logic [ACC_W_DEF-1:0] v);
    return (|v[ACC_W_DEF-1:DATA_W_DEF]) ? {DATA_W_DEF{1'b1}} : v[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/neuron_mac_unit.sv
// rtl/neuron_mac_unit.sv - operand register, unsigned multiply-accumulate, result capture and saturation
module neuron_mac_unit
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              x_en,
  input  logic              acc_en,
  input  logic              capture,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] wdata,
  output logic [ACC_W-1:0]  result,
  output logic              sat
);

  logic [DATA_W-1:0]   x;
  logic [ACC_W-1:0]    acc;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_next;

  always_comb begin
    prod     = x * din;
    acc_next = acc;
    if (clear) begin
      acc_next = '0;
    end else if (acc_en) begin
      acc_next = acc + {{(ACC_W-2*DATA_W){1'b0}}, prod};
    end
  end

  // capture sees acc_next so the final product lands in result on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x      <= '0;
      acc    <= '0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      if (x_en) x <= din;
      acc <= acc_next;
      if (capture) begin
        result <= acc_next;
        sat    <= |acc_next[ACC_W-1:DATA_W];
      end
    end
  end

  assign wdata = saturate(acc);

endmodule

// File: rtl/neuron_mac_sequencer.sv
// rtl/neuron_mac_sequencer.sv - walks (input, weight) pairs through the RAM read port and writes back the saturated sum
module neuron_mac_sequencer
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        count,
  input  logic [ADDR_W-1:0] result_addr,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_wre,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              sat
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        left;
  logic [ADDR_W-1:0] res_addr;
  logic              accept;
  logic              last_pair;
  logic              mac_clear, mac_x_en, mac_acc_en, mac_capture;
  logic [DATA_W-1:0] mac_wdata;

  assign accept    = (state == IDLE) && start;
  assign last_pair = (left == 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (count == 8'd0) ? WRITE : RD_X;
      RD_X:    state_next = RD_W;
      RD_W:    state_next = last_pair ? WRITE : RD_X;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_read_address  = '0;
    ram_oe            = 1'b0;
    ram_write_address = '0;
    ram_write_data    = '0;
    ram_wre           = 1'b0;
    busy              = (state != IDLE);
    done              = 1'b0;
    mac_clear         = accept;
    mac_x_en          = 1'b0;
    mac_acc_en        = 1'b0;
    mac_capture       = accept && (count == 8'd0);
    case (state)
      RD_X: begin
        ram_read_address = ptr;
        ram_oe           = 1'b1;
        mac_x_en         = 1'b1;
      end
      RD_W: begin
        ram_read_address = ptr + ADDR_W'(1);
        ram_oe           = 1'b1;
        mac_acc_en       = 1'b1;
        mac_capture      = last_pair;
      end
      WRITE: begin
        ram_write_address = res_addr;
        ram_write_data    = mac_wdata;
        ram_wre           = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Pointer and pair counter advance once per completed pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      left     <= '0;
      res_addr <= '0;
    end else if (accept) begin
      ptr      <= base_addr;
      left     <= count;
      res_addr <= result_addr;
    end else if (state == RD_W) begin
      ptr  <= ptr + ADDR_W'(2);
      left <= left - 8'd1;
    end
  end

  neuron_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (mac_clear),
    .x_en    (mac_x_en),
    .acc_en  (mac_acc_en),
    .capture (mac_capture),
    .din     (ram_read_data),
    .wdata   (mac_wdata),
    .result  (result),
    .sat     (sat)
  );

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb/tb_neuron_mac_sequencer.sv - directed vector bench for neuron_mac_sequencer with a behavioural RAM
module tb_neuron_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  count;
  logic [7:0]  result_addr;
  logic [7:0]  ram_read_address;
  logic        ram_oe;
  logic [7:0]  ram_read_data;
  logic [7:0]  ram_write_address;
  logic [7:0]  ram_write_data;
  logic        ram_wre;
  logic        busy;
  logic        done;
  logic [23:0] result;
  logic        sat;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  mem [256];

  int total = 0;
  int bad   = 0;
  int oe_cnt = 0;
  int wre_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  neuron_mac_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .count             (count),
    .result_addr       (result_addr),
    .ram_read_address  (ram_read_address),
    .ram_oe            (ram_oe),
    .ram_read_data     (ram_read_data),
    .ram_write_address (ram_write_address),
    .ram_write_data    (ram_write_data),
    .ram_wre           (ram_wre),
    .busy              (busy),
    .done              (done),
    .result            (result),
    .sat               (sat)
  );

  assign ram_read_data = mem[ram_read_address];

  always @(posedge clk) begin
    if (ram_wre)     mem[ram_write_address] <= ram_write_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  always @(negedge clk) begin
    if (ram_oe)  oe_cnt   <= oe_cnt + 1;
    if (ram_wre) wre_cnt  <= wre_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [7:0] base;
    logic [7:0] cnt;
    logic [7:0] raddr;
    int         exp_result;
    logic       exp_sat;
    logic [7:0] exp_mem;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [7:0] b, input logic [7:0] c, input logic [7:0] r, output int cyc);
    base_addr = b; count = c; result_addr = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_oe"}, ram_oe, 0);
    chk({tag, "_wre"}, ram_wre, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_raddr"}, ram_read_address, 0);
    chk({tag, "_waddr"}, ram_write_address, 0);
    chk({tag, "_wdata"}, ram_write_data, 0);
  endtask

  initial begin
    int cyc, o0, w0, d0;
    logic [7:0] init_data [8];

    vecs[0] = '{8'd0,  8'd2, 8'd8,  220,    1'b0, 8'd220, 6};
    vecs[1] = '{8'd4,  8'd2, 8'd9,  26,     1'b0, 8'd26,  6};
    vecs[2] = '{8'd0,  8'd4, 8'd10, 246,    1'b0, 8'd246, 10};
    vecs[3] = '{8'd16, 8'd2, 8'd11, 130050, 1'b1, 8'd255, 6};
    vecs[4] = '{8'd0,  8'd0, 8'd12, 0,      1'b0, 8'd0,   2};
    vecs[5] = '{8'd2,  8'd1, 8'd2,  110,    1'b0, 8'd110, 4};
    init_data = '{8'd10, 8'd11, 8'd10, 8'd11, 8'd4, 8'd5, 8'd3, 8'd2};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; result_addr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) preload(8'(i), init_data[i]);
    for (int i = 16; i < 20; i++) preload(8'(i), 8'd255);
    preload(8'd12, 8'd77);
    preload(8'd13, 8'd55);
    preload(8'd14, 8'd99);

    // start pulsed during RD_W of a 4-pair run must be ignored
    o0 = oe_cnt; w0 = wre_cnt; d0 = done_cnt;
    base_addr = 8'd0; count = 8'd4; result_addr = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    base_addr = 8'd0; count = 8'd0; result_addr = 8'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ign_cycles", cyc, 10);
    chk("ign_result", result, 246);
    @(posedge clk); #1;
    chk("ign_busy_after", busy, 0);
    chk("ign_done_cnt", done_cnt - d0, 1);
    chk("ign_wre_cnt", wre_cnt - w0, 1);
    chk("ign_oe_cnt", oe_cnt - o0, 8);
    chk("ign_mem13", mem[13], 246);
    chk("ign_mem12", mem[12], 77);

    // reset during RD_X of a 3-pair run aborts without write-back
    w0 = wre_cnt;
    base_addr = 8'd0; count = 8'd3; result_addr = 8'd14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_rdx_oe", ram_oe, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("midrst");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_wre_cnt", wre_cnt - w0, 0);
    chk("midrst_mem14", mem[14], 99);
    run(8'd0, 8'd3, 8'd14, cyc);
    chk("after_rst_cycles", cyc, 8);
    chk("after_rst_result", result, 240);
    @(posedge clk); #1;
    chk("after_rst_mem14", mem[14], 240);

    for (int i = 0; i < 6; i++) begin
      o0 = oe_cnt; w0 = wre_cnt; d0 = done_cnt;
      run(vecs[i].base, vecs[i].cnt, vecs[i].raddr, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      chk($sformatf("v%0d_sat", i), sat, vecs[i].exp_sat);
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy_after", i), busy, 0);
      chk($sformatf("v%0d_result_hold", i), result, vecs[i].exp_result);
      chk($sformatf("v%0d_mem", i), mem[vecs[i].raddr], vecs[i].exp_mem);
      chk($sformatf("v%0d_oe_cnt", i), oe_cnt - o0, 2 * vecs[i].cnt);
      chk($sformatf("v%0d_wre_cnt", i), wre_cnt - w0, 1);
      chk($sformatf("v%0d_done_cnt", i), done_cnt - d0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
